// File: rtl/seq_pattern_sched.sv
// seq_pattern_sched: round-robin arbiter sharing one MSB-first serial pattern generator among N_REQ requesters.
// Define SEQ_SCHED_ABORT_EN to add the abort input and aborted flag.
module seq_pattern_sched #(
  parameter int N_REQ = 4,
  parameter int W = 8,
  parameter int LW = 4,
  parameter int RW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] pat,
  input  logic [N_REQ*LW-1:0] len,
  input  logic [N_REQ*RW-1:0] rep,
  output logic [N_REQ-1:0]   grant,
  output logic               out,
  output logic               out_valid,
  output logic               done,
  output logic               busy
`ifdef SEQ_SCHED_ABORT_EN
  ,
  input  logic               abort,
  output logic               aborted
`endif
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_ptr, r_idx, w_win_idx;
  logic w_found, w_abort, w_last;
  logic [W-1:0] r_pat, r_sr, w_gpat;
  logic [LW-1:0] r_len, r_cnt, w_lraw, w_glen;
  logic [RW-1:0] r_rep, r_pass, w_grep;

  assign out = r_sr[W-1];
  assign w_gpat = pat[int'(r_idx)*W +: W];
  assign w_lraw = len[int'(r_idx)*LW +: LW];
  assign w_glen = (w_lraw == '0 || int'(w_lraw) > W) ? LW'(W) : w_lraw;
  assign w_grep = rep[int'(r_idx)*RW +: RW];
  assign w_last = r_cnt == r_len - LW'(1);

`ifdef SEQ_SCHED_ABORT_EN
  assign w_abort = abort;
  always_ff @(posedge clk)
    aborted <= !rst && r_state == RUN && abort;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_found = 1'b0;
    w_win_idx = '0;
    for (int k = 0; k < N_REQ; k++)
      if (!w_found && req[PW'((int'(r_ptr) + k) % N_REQ)]) begin
        w_found = 1'b1;
        w_win_idx = PW'((int'(r_ptr) + k) % N_REQ);
      end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_found ? LOAD : IDLE;
      LOAD:    w_next = RUN;
      RUN:     w_next = (w_abort || (w_last && r_pass == r_rep)) ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_idx     <= '0;
      grant     <= '0;
      r_pat     <= '0;
      r_sr      <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_rep     <= '0;
      r_pass    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= w_next == RUN;
      done      <= w_next == DONE;
      busy      <= w_next != IDLE;
      if (r_state == IDLE && w_found) begin
        grant <= N_REQ'(1) << w_win_idx;
        r_idx <= w_win_idx;
        r_ptr <= (w_win_idx == PW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
      end
      if (r_state == DONE)
        grant <= '0;
      if (r_state == LOAD) begin
        r_pat  <= w_gpat;
        r_sr   <= w_gpat;
        r_len  <= w_glen;
        r_rep  <= w_grep;
        r_cnt  <= '0;
        r_pass <= '0;
      end
      if (r_state == RUN) begin
        if (w_next == DONE)
          r_sr <= '0;
        else if (w_last) begin
          r_sr   <= r_pat;
          r_cnt  <= '0;
          r_pass <= r_pass + 1'b1;
        end else begin
          r_sr  <= r_sr << 1;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_pattern_sched.sv
// tb_seq_pattern_sched: directed table, corner sequences and randomized checks against a bit-string model.
module tb_seq_pattern_sched;
  logic clk, rst;
  logic [3:0] req;
  logic [31:0] pat;
  logic [15:0] len, rep;
  logic [3:0] grant;
  logic out, out_valid, done, busy;
`ifdef SEQ_SCHED_ABORT_EN
  logic abort_d, aborted;
  int abort_at;
`endif

  seq_pattern_sched dut (
    .clk(clk), .rst(rst), .req(req), .pat(pat), .len(len), .rep(rep),
    .grant(grant), .out(out), .out_valid(out_valid), .done(done), .busy(busy)
`ifdef SEQ_SCHED_ABORT_EN
    , .abort(abort_d), .aborted(aborted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] pat;
    logic [15:0] len;
    logic [15:0] rep;
    logic [3:0]  g;
    logic [63:0] bits;
    int          nb;
  } vec_t;
  vec_t tv[7];

  int n_vec, n_err, ptr;
  logic [3:0] cg;
  logic [63:0] cb;
  int cn, cd;
  logic ca, cok, cz;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic outs_zero();
    logic z;
    z = ({grant, out, out_valid, done, busy} == 8'd0);
`ifdef SEQ_SCHED_ABORT_EN
    z = z && !aborted;
`endif
    return z;
  endfunction

  // Expected stream: top L bits of the pattern, repeated rep+1 times.
  function automatic void model(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                                output logic [63:0] b, output int n);
    int lw;
    lw = (l == 0 || l > 8) ? 8 : int'(l);
    b = '0;
    n = 0;
    for (int k = 0; k <= int'(r); k++)
      for (int i = 0; i < lw; i++) begin
        b = {b[62:0], p[7-i]};
        n++;
      end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    ptr = 0;
  endtask

  // Called at an IDLE-cycle negedge; c counts cycles after the request is sampled.
  task automatic capture(input int chg_c, input logic [3:0] chg_req, input logic chg_rst, input int maxc,
                         output logic [3:0] g, output logic [63:0] bits, output int nb, output int dc,
                         output logic ab, output logic gok, output logic zr);
    g = '0; bits = '0; nb = 0; dc = -1; ab = 1'b0; gok = 1'b1; zr = 1'b0;
    for (int c = 1; c <= maxc && dc < 0; c++) begin
      @(negedge clk);
      if (c == 1) g = grant;
      else if ((c <= chg_c || !chg_rst) && (grant !== g || busy !== 1'b1)) gok = 1'b0;
      if (out_valid) begin
        bits = {bits[62:0], out};
        nb++;
      end else if (out !== 1'b0) gok = 1'b0;
      if (done) begin
        dc = c;
`ifdef SEQ_SCHED_ABORT_EN
        ab = aborted;
`endif
      end
      if (c == chg_c + 1) begin
        rst = 1'b0;
        zr = outs_zero();
      end
      if (c == chg_c) begin
        req = chg_req;
        rst = chg_rst;
      end
`ifdef SEQ_SCHED_ABORT_EN
      abort_d = (c == abort_at);
`endif
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; ptr = 0;
    rst = 1'b1; req = '0; pat = '0; len = '0; rep = '0;
`ifdef SEQ_SCHED_ABORT_EN
    abort_d = 1'b0; abort_at = -1;
`endif
    tv[0] = '{4'b0001, 32'h5AC37E9C, 16'h3756, 16'h2031, 4'b0001, 64'b100111100111, 12};
    tv[1] = '{4'b0001, 32'h112233A5, 16'h1230, 16'h0000, 4'b0001, 64'b10100101, 8};
    tv[2] = '{4'b0001, 32'h112233A5, 16'h000C, 16'h0000, 4'b0001, 64'b10100101, 8};
    tv[3] = '{4'b0001, 32'h112233A5, 16'h0001, 16'h0000, 4'b0001, 64'b1, 1};
    tv[4] = '{4'b1010, 32'hFF003CFF, 16'h8858, 16'h0020, 4'b0010, 64'b001110011100111, 15};
    tv[5] = '{4'b1010, 32'hC03C3C3C, 16'h3555, 16'h1222, 4'b1000, 64'b110110, 6};
    tv[6] = '{4'b0110, 32'h00008100, 16'h0090, 16'h0000, 4'b0010, 64'b10000001, 8};

    repeat (3) @(negedge clk);
    chk("reset_outs_zero", 64'(outs_zero()), 64'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_req_busy", 64'(busy), 64'd0);
    chk("idle_no_req_grant", 64'(grant), 64'd0);

    for (int i = 0; i < 7; i++) begin
      req = tv[i].req; pat = tv[i].pat; len = tv[i].len; rep = tv[i].rep;
      capture(-1, 4'b0, 1'b0, 60, cg, cb, cn, cd, ca, cok, cz);
      chk($sformatf("vec%0d_grant", i), 64'(cg), 64'(tv[i].g));
      chk($sformatf("vec%0d_bits", i), cb, tv[i].bits);
      chk($sformatf("vec%0d_nbits", i), 64'(cn), 64'(tv[i].nb));
      chk($sformatf("vec%0d_done_cycle", i), 64'(cd), 64'(tv[i].nb + 2));
      chk($sformatf("vec%0d_grant_held", i), 64'(cok), 64'd1);
      @(negedge clk);
    end

    do_reset();
    pat = 32'hC0C0C0C0; len = 16'h2222; rep = '0; req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      int o;
      o = (i < 5) ? i % 4 : ((i - 5) % 3) + 1;
      if (i == 5) req = 4'b1110;
      capture(-1, 4'b0, 1'b0, 20, cg, cb, cn, cd, ca, cok, cz);
      chk($sformatf("rr%0d_grant", i), 64'(cg), 64'(4'b0001 << o));
      chk($sformatf("rr%0d_done_cycle", i), 64'(cd), 64'd4);
      @(negedge clk);
    end

    req = 4'b0001; pat = 32'h000000A5; len = 16'h0008; rep = 16'h0003;
    capture(4, 4'b0000, 1'b1, 12, cg, cb, cn, cd, ca, cok, cz);
    chk("rst_mid_outs_zero", 64'(cz), 64'd1);
    chk("rst_mid_no_done", 64'(cd), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_mid_bits", cb, 64'b101);
    req = 4'b1111;
    capture(-1, 4'b0, 1'b0, 60, cg, cb, cn, cd, ca, cok, cz);
    chk("rst_mid_next_grant", 64'(cg), 64'b0001);
    @(negedge clk);

    req = 4'b0100; pat = 32'h00900000; len = 16'h0400; rep = 16'h0100;
    capture(3, 4'b0010, 1'b0, 40, cg, cb, cn, cd, ca, cok, cz);
    chk("simul_grant", 64'(cg), 64'b0100);
    chk("simul_bits", cb, 64'b10011001);
    chk("simul_done_cycle", 64'(cd), 64'd10);
    @(negedge clk);
    capture(-1, 4'b0, 1'b0, 40, cg, cb, cn, cd, ca, cok, cz);
    chk("simul_next_grant", 64'(cg), 64'b0010);
    @(negedge clk);

    req = 4'b0001; pat = 32'h000000A5; len = 16'h0008; rep = '0;
`ifdef SEQ_SCHED_ABORT_EN
    abort_at = 5;
    capture(-1, 4'b0, 1'b0, 30, cg, cb, cn, cd, ca, cok, cz);
    abort_at = -1;
    chk("abort_bits", cb, 64'b1010);
    chk("abort_nbits", 64'(cn), 64'd4);
    chk("abort_done_cycle", 64'(cd), 64'd6);
    chk("abort_flag", 64'(ca), 64'd1);
    @(negedge clk);
    abort_at = 1;
    capture(-1, 4'b0, 1'b0, 30, cg, cb, cn, cd, ca, cok, cz);
    abort_at = -1;
    chk("abort_in_load_nbits", 64'(cn), 64'd8);
    chk("abort_in_load_flag", 64'(ca), 64'd0);
`else
    capture(-1, 4'b0, 1'b0, 30, cg, cb, cn, cd, ca, cok, cz);
    chk("noabort_bits", cb, 64'b10100101);
    chk("noabort_done_cycle", 64'(cd), 64'd10);
`endif
    @(negedge clk);

    do_reset();
    for (int t = 0; t < 40; t++) begin
      logic [3:0] r;
      logic [63:0] eb;
      int w, en, cc;
      r = 4'($urandom_range(1, 15));
      pat = $urandom;
      len = 16'($urandom);
      rep = 16'($urandom) & 16'h3333;
      req = r;
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && r[(ptr + k) % 4]) w = (ptr + k) % 4;
      ptr = (w + 1) % 4;
      model(pat[w*8 +: 8], len[w*4 +: 4], rep[w*4 +: 4], eb, en);
      cc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 3)) : -1;
      capture(cc, 4'($urandom), 1'b0, 80, cg, cb, cn, cd, ca, cok, cz);
      chk($sformatf("rnd%0d_grant", t), 64'(cg), 64'(4'b0001 << w));
      chk($sformatf("rnd%0d_bits", t), cb, eb);
      chk($sformatf("rnd%0d_nbits", t), 64'(cn), 64'(en));
      chk($sformatf("rnd%0d_done_cycle", t), 64'(cd), 64'(en + 2));
      chk($sformatf("rnd%0d_grant_held", t), 64'(cok), 64'd1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
